fp_add_normalizer: RTL and testbench
====================================

Name: fp_add_normalizer

Overview:
- Back end of the pipelined FP adder: takes the aligned mantissa sum and the larger operand exponent, and produces the normalized mantissa and the adjusted exponent.
- The exponent-difference stage computes the shift that aligns the operands before the add; this block computes the shift that restores normalization after it, and adjusts the exponent to match.
- 3-stage valid/ready pipeline. Feeds the rounding stage.

Parameters:
- EXP_W, 8, exponent width (biased).
- MANT_W, 27, sum width: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- exp_in  in  EXP_W  larger biased exponent.
- mant_in  in  MANT_W  raw mantissa sum.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- exp_out  out  EXP_W  adjusted biased exponent.
- mant_out  out  MANT_W  normalized mantissa; [26]=0, [25]=hidden.
- zero_out  out  1  result is exact zero.
- ovf_out  out  1  exponent overflow; result is infinity.
- unf_out  out  1  result is denormal.

Behaviour:
- Reset (rst=0, async): all pipeline registers and valid bits clear. All outputs are 0.
- Pipeline advance: en = !out_valid | out_ready; in_ready = en. When en=0, all stages hold and no bubble collapses.
  - A beat is accepted when in_valid & in_ready.
  - Latency is exactly 3 cycles at full throughput, 1 beat per cycle.
  - out_valid and data stay stable while out_valid & !out_ready.
- S1: register exp_in and mant_in. Compute lz = number of leading zeros of mant_in[25:0], counted from bit 25, range 0..26 (26 when the field is all zeros). Register lz and the carry bit.
- S2: classify the beat and compute shift direction, shift amount, exponent and flags.
  - Carry (M[26]=1): right shift by 1, new [0] = M[1]|M[0] (sticky kept); E' = E+1.
    - If E' == 255: ovf=1, exp_out=255, mant_out=0.
  - Zero (M==0): zero=1, exp_out=0, mant_out=0.
  - E == 0 (denormal inputs): shift 0. exp_out = M[25] ? 1 : 0. unf = !M[25].
  - Otherwise: left shift by sh = min(lz, E-1); E' = E-sh. Zeros fill from the LSB.
    - If the shifted [25] == 0: exp_out=0 and unf=1.
- S3: apply the barrel shift and register all outputs.
- Flags are mutually exclusive.
- Width rules: the exponent is computed in EXP_W+1 bits to detect 255; no wrap-around is allowed. sh is at most 26.
- Reset mid-stream drops all in-flight beats; nothing is output after reset deasserts until a new beat has travelled 3 stages.
- Simultaneous accept and output: legal every cycle when out_ready=1.

Decomposition:
- Shared package fp_add_pkg holds:
  - EXP_MAX = 8'hFF;
  - bit indices CARRY_BIT=26, HIDDEN_BIT=25, GUARD_BIT=1, STICKY_BIT=0;
  - a typedef for the 27-bit mantissa sum.
- One sub-module: lzc_26, a combinational leading-zero counter. Input [25:0]; output 5-bit count plus an all_zero flag.
- Pipeline registers use the codebase's existing bit_1_reg and bit_8_reg style.

Test Plan:
- E=8'h80, M=27'h4000000 (carry set) -> 3 cycles later exp_out=8'h81, mant_out=27'h2000000, all flags 0.
- E=8'h80, M=27'h0400000 (lz=3) -> exp_out=8'h7D, mant_out=27'h2000000, flags 0.
- E=8'h02, M=27'h0100000 (lz=5, clamped to 1) -> exp_out=8'h00, mant_out=27'h0200000, unf=1.
- E=8'hFE, M=27'h4000001 -> exp_out=8'hFF, mant_out=0, ovf=1.
- M=0 with any E -> zero_out=1, exp_out=0, mant_out=0.
- Streaming and reset:
  - Stream 10 back-to-back beats with out_ready low for cycles 4-6 -> in_ready low in those cycles, no beat lost or duplicated, order preserved.
  - Assert rst low mid-stream -> out_valid=0 immediately (asynchronously).

Source files
------------

// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared constants and types for the FP adder back end
//
// Purpose : Exponent limit, mantissa-sum bit positions, the mantissa-sum
//           type and the shift-direction encoding used between the
//           classify and shift stages of the normalizer.
// Ports   : none (package).

package fp_add_pkg;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    // Bit positions inside the 27-bit aligned mantissa sum.
    localparam int CARRY_BIT  = 26;
    localparam int HIDDEN_BIT = 25;
    localparam int GUARD_BIT  = 1;
    localparam int STICKY_BIT = 0;

    typedef logic [26:0] mant_sum_t;

    typedef enum logic [1:0] {
        SH_NONE  = 2'd0,
        SH_RIGHT = 2'd1,
        SH_LEFT  = 2'd2
    } shift_dir_t;

endpackage

// File: rtl/lzc_26.sv
// rtl/lzc_26.sv - combinational leading-zero counter for a 26-bit field
//
// Purpose : Counts leading zeros of din starting at bit 25. Returns 26 and
//           raises all_zero when no bit is set.
// Ports   : din      in  [25:0]  field to scan (hidden bit down to sticky)
//           count    out [4:0]   leading-zero count, 0..26
//           all_zero out         din has no bit set

module lzc_26 (
    input  logic [25:0] din,
    output logic [4:0]  count,
    output logic        all_zero
);

    logic found;

    always_comb begin
        count = 5'd26;
        found = 1'b0;
        for (int i = 25; i >= 0; i--) begin
            if (!found && din[i]) begin
                count = 5'(25 - i);
                found = 1'b1;
            end
        end
    end

    assign all_zero = ~|din;

endmodule

// File: rtl/fp_add_normalizer.sv
// rtl/fp_add_normalizer.sv - 3-stage post-add normalizer for the FP adder
//
// Purpose : Takes the aligned mantissa sum and the larger biased exponent,
//           shifts the sum back into normalized form and adjusts the
//           exponent, flagging zero, overflow (infinity) and denormal.
//           S1 registers the beat with its leading-zero count, S2 picks the
//           shift direction/amount and the exponent, S3 applies the shift.
// Ports   : clk        in   clock, rising edge
//           rst        in   asynchronous active-low reset
//           in_valid   in   input beat valid
//           in_ready   out  block accepts a beat this cycle
//           exp_in     in   [EXP_W-1:0]  larger biased exponent
//           mant_in    in   [MANT_W-1:0] raw mantissa sum
//           out_valid  out  result valid
//           out_ready  in   downstream accepts the result
//           exp_out    out  [EXP_W-1:0]  adjusted biased exponent
//           mant_out   out  [MANT_W-1:0] normalized mantissa, [26]=0
//           zero_out   out  result is exact zero
//           ovf_out    out  exponent overflow, result is infinity
//           unf_out    out  result is denormal

module fp_add_normalizer
    import fp_add_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic              zero_out,
    output logic              ovf_out,
    output logic              unf_out
);

    // The whole pipe moves as one: a stalled output freezes every stage,
    // so bubbles are never squeezed out while stalled.
    logic en;
    assign en       = !out_valid || out_ready;
    // Held low while in reset so every output reads 0.
    assign in_ready = en && rst;

    // ---------------------------------------------------------------- S1
    logic [4:0] lz;
    logic       lz_all_zero;

    lzc_26 u_lzc (
        .din      (mant_in[HIDDEN_BIT:0]),
        .count    (lz),
        .all_zero (lz_all_zero)
    );

    logic             s1_valid;
    logic [EXP_W-1:0] s1_exp;
    mant_sum_t        s1_mant;
    logic [4:0]       s1_lz;
    logic             s1_carry;
    logic             s1_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lz    <= '0;
            s1_carry <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_exp   <= exp_in;
            s1_mant  <= mant_in;
            s1_lz    <= lz;
            s1_carry <= mant_in[CARRY_BIT];
            s1_zero  <= lz_all_zero && !mant_in[CARRY_BIT];
        end
    end

    // ---------------------------------------------------------------- S2
    // Exponent arithmetic is one bit wider so E+1 can reach EXP_MAX+1
    // without wrapping back to a small exponent.
    logic [EXP_W:0]   exp_inc;
    logic [EXP_W-1:0] sh_limit;
    shift_dir_t       d2_dir;
    logic [4:0]       d2_sh;
    logic [EXP_W-1:0] d2_exp;
    logic             d2_zero;
    logic             d2_ovf;
    logic             d2_unf;

    always_comb begin
        d2_dir   = SH_NONE;
        d2_sh    = '0;
        d2_exp   = '0;
        d2_zero  = 1'b0;
        d2_ovf   = 1'b0;
        d2_unf   = 1'b0;
        exp_inc  = {1'b0, s1_exp} + (EXP_W+1)'(1);
        // A left shift may lower the exponent to 1 at most; past that the
        // result stays denormal with exponent 0.
        sh_limit = s1_exp - EXP_W'(1);

        if (s1_carry) begin
            if (exp_inc >= {1'b0, EXP_MAX}) begin
                d2_ovf = 1'b1;
                d2_exp = EXP_MAX;
            end else begin
                d2_dir = SH_RIGHT;
                d2_exp = exp_inc[EXP_W-1:0];
            end
        end else if (s1_zero) begin
            d2_zero = 1'b1;
        end else if (s1_exp == '0) begin
            // Denormal operands: the sum is already in place; a set hidden
            // bit means it grew into the smallest normal.
            d2_exp = EXP_W'(s1_mant[HIDDEN_BIT]);
            d2_unf = !s1_mant[HIDDEN_BIT];
        end else begin
            d2_dir = SH_LEFT;
            if (EXP_W'(s1_lz) <= sh_limit) begin
                d2_sh = s1_lz;
            end else begin
                d2_sh = sh_limit[4:0];
            end
            // The hidden bit lands on [25] only when the full lz is applied;
            // a clamped shift leaves a denormal.
            d2_unf = (d2_sh != s1_lz);
            d2_exp = d2_unf ? '0 : s1_exp - EXP_W'(d2_sh);
        end
    end

    logic             s2_valid;
    mant_sum_t        s2_mant;
    shift_dir_t       s2_dir;
    logic [4:0]       s2_sh;
    logic [EXP_W-1:0] s2_exp;
    logic             s2_zero;
    logic             s2_ovf;
    logic             s2_unf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_mant  <= '0;
            s2_dir   <= SH_NONE;
            s2_sh    <= '0;
            s2_exp   <= '0;
            s2_zero  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_mant  <= s1_mant;
            s2_dir   <= d2_dir;
            s2_sh    <= d2_sh;
            s2_exp   <= d2_exp;
            s2_zero  <= d2_zero;
            s2_ovf   <= d2_ovf;
            s2_unf   <= d2_unf;
        end
    end

    // ---------------------------------------------------------------- S3
    mant_sum_t d3_mant;

    always_comb begin
        case (s2_dir)
            // Right shift folds the dropped guard bit into sticky.
            SH_RIGHT: d3_mant = {1'b0, s2_mant[CARRY_BIT:2],
                                 s2_mant[GUARD_BIT] | s2_mant[STICKY_BIT]};
            SH_LEFT:  d3_mant = s2_mant << s2_sh;
            default:  d3_mant = s2_mant;
        endcase
        if (s2_zero || s2_ovf) begin
            d3_mant = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            exp_out   <= '0;
            mant_out  <= '0;
            zero_out  <= 1'b0;
            ovf_out   <= 1'b0;
            unf_out   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            exp_out   <= s2_exp;
            mant_out  <= d3_mant;
            zero_out  <= s2_zero;
            ovf_out   <= s2_ovf;
            unf_out   <= s2_unf;
        end
    end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// tb/tb_fp_add_normalizer.sv - self-checking bench for fp_add_normalizer

module tb_fp_add_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [26:0] mant_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  exp_out;
    logic [26:0] mant_out;
    logic        zero_out;
    logic        ovf_out;
    logic        unf_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_add_normalizer #(.EXP_W(8), .MANT_W(27)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .mant_out  (mant_out),
        .zero_out  (zero_out),
        .ovf_out   (ovf_out),
        .unf_out   (unf_out)
    );

    typedef struct packed {
        logic [7:0]  e;
        logic [26:0] m;
        logic        z;
        logic        o;
        logic        u;
    } res_t;

    typedef struct {
        string       name;
        logic [7:0]  e_in;
        logic [26:0] m_in;
        res_t        want;
    } vec_t;

    vec_t vq[$];

    // Reference: normalize by repeated doubling while the exponent allows it.
    function automatic res_t model(logic [7:0] e, logic [26:0] m);
        res_t        r;
        int          ex;
        logic [26:0] mm;
        r = '0;
        if (m[26]) begin
            ex = int'(e) + 1;
            if (ex >= 255) begin
                r.o = 1'b1;
                r.e = 8'hFF;
            end else begin
                r.e = 8'(ex);
                r.m = (m >> 1) | {26'b0, m[0]};
            end
        end else if (m == 27'd0) begin
            r.z = 1'b1;
        end else if (e == 8'd0) begin
            r.m = m;
            r.e = m[25] ? 8'd1 : 8'd0;
            r.u = !m[25];
        end else begin
            ex = int'(e);
            mm = m;
            while (ex > 1 && !mm[25]) begin
                mm = mm << 1;
                ex--;
            end
            r.m = mm;
            if (mm[25]) r.e = 8'(ex);
            else r.u = 1'b1;
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r = {exp_out, mant_out, zero_out, ovf_out, unf_out};
        return r;
    endfunction

    task automatic check_res(string name, res_t act, res_t want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got exp=%h mant=%h z=%b o=%b u=%b, want exp=%h mant=%h z=%b o=%b u=%b",
                     name, act.e, act.m, act.z, act.o, act.u, want.e, want.m, want.z, want.o, want.u);
        end
    endtask

    task automatic check_bit(string name, logic act, logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %b, want %b", name, act, want);
        end
    endtask

    task automatic check_int(string name, int act, int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic add_vec(string name, logic [7:0] e, logic [26:0] m,
                           logic [7:0] we, logic [26:0] wm, logic z, logic o, logic u);
        vec_t v;
        v.name = name;
        v.e_in = e;
        v.m_in = m;
        v.want = {we, wm, z, o, u};
        vq.push_back(v);
    endtask

    function automatic logic [26:0] rand_mant();
        logic [26:0] m;
        int k;
        k = $urandom_range(9);
        m = 27'($urandom);
        if (k == 0) m = '0;
        else if (k < 3) m[26] = 1'b1;
        else begin
            m[26] = 1'b0;
            m = m >> $urandom_range(26);
        end
        return m;
    endfunction

    function automatic logic [7:0] rand_exp();
        int k;
        k = $urandom_range(9);
        if (k == 0) return 8'd0;
        if (k == 1) return 8'd254;
        if (k == 2) return 8'($urandom_range(4, 1));
        return 8'($urandom_range(254, 1));
    endfunction

    // One isolated beat: checks acceptance, 3-cycle latency, data, drain.
    task automatic single(vec_t v);
        int cyc;
        @(negedge clk);
        exp_in = v.e_in;
        mant_in = v.m_in;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check_bit({v.name, " in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_int({v.name, " latency"}, cyc, 3);
        check_res(v.name, dut_res(), v.want);
        @(negedge clk);
        check_bit({v.name, " drained"}, out_valid, 1'b0);
    endtask

    // Streams n beats through a scoreboard. scripted: back-to-back input,
    // out_ready low in cycles 4..6; otherwise random valid/ready.
    task automatic stream(int n, bit scripted, string tag);
        res_t q[$];
        res_t want;
        res_t held;
        bit   hold = 1'b0;
        bit   pending = 1'b0;
        int   offered = 0;
        int   recv = 0;
        int   cyc = 0;
        int   extra = 0;
        in_valid = 1'b0;
        while (recv < n && cyc < 5000) begin
            @(negedge clk);
            if (!pending) begin
                if (offered < n && (scripted || $urandom_range(3) != 0)) begin
                    exp_in = rand_exp();
                    mant_in = rand_mant();
                    in_valid = 1'b1;
                    offered++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (scripted) out_ready = !(cyc >= 4 && cyc <= 6);
            else out_ready = ($urandom_range(3) != 0);
            #1;
            if (scripted && cyc >= 4 && cyc <= 6)
                check_bit({tag, " stall in_ready"}, in_ready, 1'b0);
            if (hold) begin
                check_bit({tag, " hold valid"}, out_valid, 1'b1);
                check_res({tag, " hold data"}, dut_res(), held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_bit({tag, " unexpected output"}, out_valid, 1'b0);
                end else begin
                    want = q.pop_front();
                    check_res($sformatf("%s beat %0d", tag, recv), dut_res(), want);
                end
                recv++;
            end
            hold = out_valid && !out_ready;
            held = dut_res();
            if (in_valid && in_ready) begin
                q.push_back(model(exp_in, mant_in));
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_int({tag, " beats received"}, recv, n);
        check_int({tag, " beats left over"}, q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 if (out_valid) extra++;
        end
        check_int({tag, " extra outputs"}, extra, 0);
    endtask

    initial begin
        add_vec("carry",         8'h80, 27'h4000000, 8'h81, 27'h2000000, 0, 0, 0);
        add_vec("lz3",           8'h80, 27'h0400000, 8'h7D, 27'h2000000, 0, 0, 0);
        add_vec("clamp_unf",     8'h02, 27'h0100000, 8'h00, 27'h0200000, 0, 0, 1);
        add_vec("ovf",           8'hFE, 27'h4000001, 8'hFF, 27'h0000000, 0, 1, 0);
        add_vec("zero",          8'h37, 27'h0000000, 8'h00, 27'h0000000, 1, 0, 0);
        add_vec("zero_e0",       8'h00, 27'h0000000, 8'h00, 27'h0000000, 1, 0, 0);
        add_vec("already_norm",  8'h10, 27'h3FFFFFF, 8'h10, 27'h3FFFFFF, 0, 0, 0);
        add_vec("lz25",          8'h80, 27'h0000001, 8'h67, 27'h2000000, 0, 0, 0);
        add_vec("den_to_norm",   8'h00, 27'h2000001, 8'h01, 27'h2000001, 0, 0, 0);
        add_vec("den_stays",     8'h00, 27'h1000000, 8'h00, 27'h1000000, 0, 0, 1);
        add_vec("carry_sticky",  8'h40, 27'h6000003, 8'h41, 27'h3000001, 0, 0, 0);
        add_vec("e1_no_shift",   8'h01, 27'h0000003, 8'h00, 27'h0000003, 0, 0, 1);
        add_vec("exact_limit",   8'h04, 27'h0400000, 8'h01, 27'h2000000, 0, 0, 0);
        add_vec("carry_to_fe",   8'hFD, 27'h4000000, 8'hFE, 27'h2000000, 0, 0, 0);
        add_vec("carry_e0",      8'h00, 27'h7FFFFFF, 8'h01, 27'h3FFFFFF, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check_res("reset outputs", dut_res(), '0);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_bit("reset in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) single(vq[i]);

        stream(10, 1'b1, "stall");
        stream(300, 1'b0, "random");

        // Reset in the middle of a full-rate stream
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_in = rand_exp();
            mant_in = rand_mant();
            in_valid = 1'b1;
        end
        #1 check_bit("pre-reset out_valid", out_valid, 1'b1);
        #1 rst = 1'b0;
        #1;
        check_bit("async reset out_valid", out_valid, 1'b0);
        check_res("async reset outputs", dut_res(), '0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                #1 if (out_valid) seen++;
            end
            check_int("post-reset ghost outputs", seen, 0);
        end
        single(vq[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, want done");
        $fatal(1, "timeout");
    end

endmodule
